// File: rtl/counter_ctrl.sv
// Command sequencer for the 4-bit mode counter: loads a start value, runs a
// programmed number of steps, tracks wrap-arounds and reports the final count.
module counter_ctrl #(
  parameter int STEPS_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [1:0]         CMD_MODO,
  input  logic [3:0]         CMD_D,
  input  logic [STEPS_W-1:0] CMD_STEPS,
  output logic               CNT_ENABLE,
  output logic               CNT_RESET,
  output logic [1:0]         CNT_MODO,
  output logic [3:0]         CNT_D,
  input  logic [3:0]         CNT_Q,
  input  logic               CNT_LOAD,
  output logic               DONE,
  output logic [3:0]         RESULT,
  output logic [3:0]         WRAPS,
  output logic               ERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [3:0]         d_q, d_d;
  logic [STEPS_W-1:0] rem_q, rem_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [3:0]         result_q, result_d;
  logic [3:0]         wraps_q, wraps_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               chk_q, chk_d;
  logic               wrap_hit;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'b00;
      d_q      <= 4'd0;
      rem_q    <= '0;
      wcnt_q   <= 4'd0;
      result_q <= 4'd0;
      wraps_q  <= 4'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      chk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      d_q      <= d_d;
      rem_q    <= rem_d;
      wcnt_q   <= wcnt_d;
      result_q <= result_d;
      wraps_q  <= wraps_d;
      done_q   <= done_d;
      err_q    <= err_d;
      chk_q    <= chk_d;
    end
  end

  // Wrap is judged on the value the counter holds before this cycle's step.
  always_comb begin
    wrap_hit = 1'b0;
    case (mode_q)
      2'b00:   wrap_hit = (CNT_Q < 4'd3);
      2'b01:   wrap_hit = (CNT_Q == 4'd0);
      2'b10:   wrap_hit = (CNT_Q == 4'd15);
      default: wrap_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    d_d        = d_q;
    rem_d      = rem_q;
    wcnt_d     = wcnt_q;
    result_d   = result_q;
    wraps_d    = wraps_q;
    done_d     = 1'b0;
    err_d      = err_q;
    chk_d      = (state_q == S_LOAD);
    CMD_READY  = 1'b0;
    CNT_ENABLE = 1'b0;
    CNT_MODO   = mode_q;
    CNT_D      = d_q;

    // The counter acknowledges the load one cycle after the LOAD state.
    if (chk_q && !CNT_LOAD) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          mode_d  = CMD_MODO;
          d_d     = CMD_D;
          rem_d   = CMD_STEPS;
          wcnt_d  = 4'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        CNT_ENABLE = 1'b1;
        CNT_MODO   = 2'b11;
        state_d    = (rem_q == '0) ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        CNT_ENABLE = 1'b1;
        rem_d      = rem_q - STEPS_W'(1);
        if (wrap_hit && wcnt_q != 4'd15) begin
          wcnt_d = wcnt_q + 4'd1;
        end
        if (rem_q == STEPS_W'(1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        result_d = CNT_Q;
        wraps_d  = wcnt_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign CNT_RESET = RESET;
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign WRAPS     = wraps_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: behavioural counter4b model, directed commands,
// scoreboard queue checked by an independent DONE monitor.
module tb_counter_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_MODO;
  logic [3:0] CMD_D;
  logic [7:0] CMD_STEPS;
  logic       CNT_ENABLE;
  logic       CNT_RESET;
  logic [1:0] CNT_MODO;
  logic [3:0] CNT_D;
  logic [3:0] CNT_Q;
  logic       CNT_LOAD;
  logic       DONE;
  logic [3:0] RESULT;
  logic [3:0] WRAPS;
  logic       ERR;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic force_ack0 = 1'b0;
  logic cl;

  typedef struct {
    logic [3:0] res;
    logic [3:0] wraps;
    logic       err;
    int         done_cyc;
  } exp_t;
  exp_t sb[$];

  counter_ctrl #(.STEPS_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_MODO(CMD_MODO), .CMD_D(CMD_D), .CMD_STEPS(CMD_STEPS),
    .CNT_ENABLE(CNT_ENABLE), .CNT_RESET(CNT_RESET), .CNT_MODO(CNT_MODO),
    .CNT_D(CNT_D), .CNT_Q(CNT_Q), .CNT_LOAD(CNT_LOAD), .DONE(DONE),
    .RESULT(RESULT), .WRAPS(WRAPS), .ERR(ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // counter4b model: disabled clears, 11 loads D, other modes step mod 16
  always @(posedge CLK) begin
    if (CNT_RESET || !CNT_ENABLE) begin
      CNT_Q <= 4'd0;
      cl    <= 1'b0;
    end else begin
      cl <= (CNT_MODO == 2'b11);
      case (CNT_MODO)
        2'b00:   CNT_Q <= CNT_Q - 4'd3;
        2'b01:   CNT_Q <= CNT_Q - 4'd1;
        2'b10:   CNT_Q <= CNT_Q + 4'd1;
        default: CNT_Q <= CNT_D;
      endcase
    end
  end
  assign CNT_LOAD = cl & ~force_ack0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest expected completion.
  always @(negedge CLK) begin
    if (!RESET && DONE) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", int'(RESULT), int'(e.res));
        check("wraps", int'(WRAPS), int'(e.wraps));
        check("err", int'(ERR), int'(e.err));
        check("done_cycle", cyc, e.done_cyc);
        $display("done: result=%0d wraps=%0d err=%0d cycle=%0d", RESULT, WRAPS, ERR, cyc);
      end
    end
  end

  // Drives a command (valid stays high) and records the expected completion.
  task automatic send(input logic [1:0] m, input logic [3:0] d, input logic [7:0] n,
                      input logic [3:0] er, input logic [3:0] ew, input logic ee);
    exp_t e;
    int guard;
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_MODO  = m;
    CMD_D     = d;
    CMD_STEPS = n;
    guard = 0;
    while (!CMD_READY && guard < 1000) begin
      @(negedge CLK);
      guard++;
    end
    if (!CMD_READY) check("ready_timeout", 0, 1);
    @(posedge CLK);
    #1;
    e.res = er; e.wraps = ew; e.err = ee; e.done_cyc = cyc + int'(n) + 2;
    sb.push_back(e);
    $display("cmd: mode=%b d=%0d steps=%0d accepted at cycle %0d", m, d, n, cyc);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      @(negedge CLK);
      guard++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic drop_valid();
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_modo [4];
    RESET = 1'b1; CMD_VALID = 1'b0; CMD_MODO = 2'b00; CMD_D = 4'd0; CMD_STEPS = 8'd0;
    repeat (2) @(negedge CLK);
    check("reset_cnt_reset", int'(CNT_RESET), 1);
    check("reset_ready", int'(CMD_READY), 1);
    check("reset_done", int'(DONE), 0);
    check("reset_result", int'(RESULT), 0);
    check("reset_wraps", int'(WRAPS), 0);
    check("reset_err", int'(ERR), 0);
    RESET = 1'b0;
    @(negedge CLK);
    check("cnt_reset_released", int'(CNT_RESET), 0);

    // D=5 +1 x3, with counter-drive sequence check
    send(2'b10, 4'd5, 8'd3, 4'd8, 4'd0, 1'b0);
    CMD_VALID = 1'b0;
    exp_modo[0] = 2'b11; exp_modo[1] = 2'b10; exp_modo[2] = 2'b10; exp_modo[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("cnt_modo_seq", int'(CNT_MODO), int'(exp_modo[i]));
      check("cnt_enable_seq", int'(CNT_ENABLE), 1);
    end
    @(negedge CLK);
    check("finish_enable", int'(CNT_ENABLE), 0);
    drain();

    send(2'b10, 4'd14, 8'd4, 4'd2, 4'd1, 1'b0);  drop_valid(); drain();
    send(2'b00, 4'd1, 8'd2, 4'd11, 4'd1, 1'b0);  drop_valid(); drain();
    send(2'b10, 4'd9, 8'd0, 4'd9, 4'd0, 1'b0);   drop_valid(); drain();
    send(2'b01, 4'd0, 8'd255, 4'd1, 4'd15, 1'b0); drop_valid(); drain();
    send(2'b11, 4'd7, 8'd5, 4'd7, 4'd0, 1'b0);   drop_valid(); drain();

    // back-to-back: second command taken in the DONE cycle of the first
    send(2'b10, 4'd3, 8'd1, 4'd4, 4'd0, 1'b0);
    send(2'b01, 4'd0, 8'd2, 4'd14, 4'd1, 1'b0);
    drop_valid(); drain();

    // reset during RUN aborts the command
    send(2'b10, 4'd3, 8'd10, 4'd0, 4'd0, 1'b0);
    CMD_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    sb.delete();
    @(negedge CLK);
    RESET = 1'b0;
    check("abort_ready", int'(CMD_READY), 1);
    check("abort_done", int'(DONE), 0);
    check("abort_result", int'(RESULT), 0);
    check("abort_wraps", int'(WRAPS), 0);
    repeat (14) @(negedge CLK);
    check("abort_no_done", int'(DONE), 0);

    // missing load acknowledge sets sticky ERR
    force_ack0 = 1'b1;
    send(2'b10, 4'd2, 8'd2, 4'd4, 4'd0, 1'b1); drop_valid(); drain();
    force_ack0 = 1'b0;
    send(2'b00, 4'd6, 8'd1, 4'd3, 4'd0, 1'b1); drop_valid(); drain();
    check("err_sticky", int'(ERR), 1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("err_cleared", int'(ERR), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
